// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the MIPS pipeline stage registers: the NOP control
// encoding, control-bit positions and per-stage payload widths.
package pipe_stage_reg_pkg;

  localparam int CTRL_W_DEF = 9;
  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

  // Bit positions inside the control vector carried between stages
  localparam int CTRL_JR       = 0;
  localparam int CTRL_JAL      = 1;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_BEQ      = 3;
  localparam int CTRL_BNE      = 4;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_REGWRITE = 8;

  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_DATA_W  = 138;
  localparam int EX_MEM_DATA_W = 102;
  localparam int MEM_WB_DATA_W = 69;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline slot: payload, control vector and valid bit with load/clear.
// Clearing drops valid and zeroes control so an empty slot always reads as NOP.
module pipe_entry
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clear beats load so a flush can never let a beat slip through
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, stall, flush,
// optional skid entry and a saturating backpressure counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              accept;
  logic              consume;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .valid_o (out_valid),
    .data_o  (out_data),
    .ctrl_o  (out_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid;
      logic              skid_load;
      logic              skid_clear;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
      );

      // Ready depends only on skid occupancy, so upstream never sees a path from out_ready
      assign in_ready = !skid_valid && !stall;

      always_comb begin
        main_load   = 1'b0;
        main_clear  = 1'b0;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        if (flush) begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else if (consume || !out_valid) begin
          if (skid_valid) begin
            main_load   = 1'b1;
            main_data_d = skid_data;
            main_ctrl_d = skid_ctrl;
            skid_clear  = 1'b1;
          end else if (accept) begin
            main_load = 1'b1;
          end else begin
            main_clear = 1'b1;
          end
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = (!out_valid || out_ready) && !stall;

      always_comb begin
        main_load   = 1'b0;
        main_clear  = 1'b0;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
        if (flush) begin
          main_clear = 1'b1;
        end else if (accept) begin
          main_load = 1'b1;
        end else if (consume) begin
          main_clear = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance driven from a vector
// table, plus hand-written sequences for reset, saturation and the SKID=0 variant.
module tb_pipe_stage_reg;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [101:0] in_data;
  logic [8:0]   in_ctrl;
  logic         stall;
  logic         flush;
  logic         out_ready;

  logic         a_ir, a_ov, b_ir, b_ov;
  logic [101:0] a_od, b_od;
  logic [8:0]   a_oc, b_oc;
  logic [3:0]   a_cnt, b_cnt;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic         iv;
    logic [101:0] d;
    logic [8:0]   c;
    logic         st;
    logic         fl;
    logic         ordy;
    logic         eir;
    logic         eov;
    logic [101:0] eod;
    logic [8:0]   eoc;
    logic [3:0]   ecnt;
    logic         chkd;
  } vec_t;

  vec_t vecs[33];

  pipe_stage_reg #(.DATA_W(102), .CTRL_W(9), .SKID(1), .CNT_W(4)) dutA (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_ctrl(a_oc), .stall_cnt(a_cnt)
  );

  pipe_stage_reg #(.DATA_W(102), .CTRL_W(9), .SKID(0), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_ctrl(b_oc), .stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input logic iv, input logic [101:0] d, input logic [8:0] c,
                              input logic st, input logic fl, input logic ordy,
                              input logic eir, input logic eov, input logic [101:0] eod,
                              input logic [8:0] eoc, input logic [3:0] ecnt, input logic chkd);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.st = st; v.fl = fl; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eod = eod; v.eoc = eoc; v.ecnt = ecnt; v.chkd = chkd;
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, then settle before checking
  task automatic applyStimulus(input logic iv, input logic [101:0] d, input logic [8:0] c,
                               input logic st, input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    vecs[0]  = mk(1, 'h1,  'h101, 0, 0, 1,  1, 0, 0,    0,     0,  0);
    vecs[1]  = mk(1, 'h2,  'h102, 0, 0, 1,  1, 1, 'h1, 'h101, 0,  1);
    vecs[2]  = mk(1, 'h3,  'h103, 0, 0, 1,  1, 1, 'h2, 'h102, 0,  1);
    vecs[3]  = mk(1, 'h4,  'h104, 0, 0, 1,  1, 1, 'h3, 'h103, 0,  1);
    vecs[4]  = mk(0, 0,    0,     0, 0, 1,  1, 1, 'h4, 'h104, 0,  1);
    vecs[5]  = mk(0, 0,    0,     0, 0, 1,  1, 0, 0,    0,     0,  0);
    vecs[6]  = mk(1, 'hA,  'h0AA, 0, 0, 0,  1, 0, 0,    0,     0,  0);
    vecs[7]  = mk(1, 'hB,  'h0BB, 0, 0, 0,  1, 1, 'hA, 'h0AA, 0,  1);
    vecs[8]  = mk(1, 'hC,  'h0CC, 0, 0, 0,  0, 1, 'hA, 'h0AA, 1,  1);
    vecs[9]  = mk(1, 'hC,  'h0CC, 0, 0, 0,  0, 1, 'hA, 'h0AA, 2,  1);
    vecs[10] = mk(1, 'hC,  'h0CC, 0, 0, 1,  0, 1, 'hA, 'h0AA, 3,  1);
    vecs[11] = mk(1, 'hC,  'h0CC, 0, 0, 1,  1, 1, 'hB, 'h0BB, 3,  1);
    vecs[12] = mk(0, 0,    0,     0, 0, 1,  1, 1, 'hC, 'h0CC, 3,  1);
    vecs[13] = mk(0, 0,    0,     0, 0, 1,  1, 0, 0,    0,     3,  0);
    vecs[14] = mk(1, 'h11, 'h111, 0, 0, 0,  1, 0, 0,    0,     3,  0);
    vecs[15] = mk(1, 'h22, 'h122, 0, 0, 0,  1, 1, 'h11, 'h111, 3,  1);
    vecs[16] = mk(1, 'h33, 'h133, 0, 1, 0,  0, 1, 'h11, 'h111, 4,  1);
    vecs[17] = mk(0, 0,    0,     0, 0, 1,  1, 0, 0,    0,     5,  0);
    vecs[18] = mk(1, 'h44, 'h144, 0, 0, 1,  1, 0, 0,    0,     5,  0);
    vecs[19] = mk(1, 'h55, 'h155, 0, 1, 0,  1, 1, 'h44, 'h144, 5,  1);
    vecs[20] = mk(0, 0,    0,     0, 0, 1,  1, 0, 0,    0,     6,  0);
    vecs[21] = mk(1, 'h66, 'h166, 0, 0, 0,  1, 0, 0,    0,     6,  0);
    vecs[22] = mk(1, 'h77, 'h177, 1, 0, 0,  0, 1, 'h66, 'h166, 6,  1);
    vecs[23] = mk(1, 'h77, 'h177, 1, 0, 0,  0, 1, 'h66, 'h166, 7,  1);
    vecs[24] = mk(1, 'h77, 'h177, 1, 0, 0,  0, 1, 'h66, 'h166, 8,  1);
    vecs[25] = mk(1, 'h77, 'h177, 1, 0, 0,  0, 1, 'h66, 'h166, 9,  1);
    vecs[26] = mk(1, 'h77, 'h177, 1, 1, 0,  0, 1, 'h66, 'h166, 10, 1);
    vecs[27] = mk(0, 0,    0,     0, 0, 1,  1, 0, 0,    0,     11, 0);
    vecs[28] = mk(1, 'h88, 'h188, 0, 0, 1,  1, 0, 0,    0,     11, 0);
    vecs[29] = mk(1, 'h99, 'h199, 1, 0, 1,  0, 1, 'h88, 'h188, 11, 1);
    vecs[30] = mk(0, 0,    0,     0, 0, 1,  1, 0, 0,    0,     11, 0);
    vecs[31] = mk(1, 'hAB, 'h1AB, 0, 0, 0,  1, 0, 0,    0,     11, 0);
    vecs[32] = mk(1, 'hCD, 'h1CD, 0, 0, 0,  1, 1, 'hAB, 'h1AB, 11, 1);

    // Reset held with a live all-ones control beat presented
    reset = 1'b0; in_valid = 1'b1; in_data = '1; in_ctrl = 9'h1FF;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    checkOutput("reset.a_valid", a_ov, 0);
    checkOutput("reset.a_ctrl", a_oc, 0);
    checkOutput("reset.a_cnt", a_cnt, 0);
    checkOutput("reset.b_valid", b_ov, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("reset.a_ready", a_ir, 1);
    checkOutput("reset.a_valid_after", a_ov, 0);
    checkOutput("reset.b_ready", b_ir, 1);

    for (int i = 0; i < 33; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].st, vecs[i].fl, vecs[i].ordy);
      checkOutput($sformatf("row%0d.in_ready", i), a_ir, vecs[i].eir);
      checkOutput($sformatf("row%0d.out_valid", i), a_ov, vecs[i].eov);
      checkOutput($sformatf("row%0d.out_ctrl", i), a_oc, vecs[i].eoc);
      checkOutput($sformatf("row%0d.stall_cnt", i), a_cnt, vecs[i].ecnt);
      if (vecs[i].chkd) checkOutput($sformatf("row%0d.out_data", i), a_od, vecs[i].eod);
    end

    // Main=AB, skid=CD: an asynchronous reset must drop both beats
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("midrst.ready_before", a_ir, 0);
    checkOutput("midrst.cnt_before", a_cnt, 12);
    checkOutput("midrst.data_before", a_od, 'hAB);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst.valid", a_ov, 0);
    checkOutput("midrst.ctrl", a_oc, 0);
    checkOutput("midrst.cnt", a_cnt, 0);
    checkOutput("midrst.ready", a_ir, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("midrst.empty%0d", k), a_ov, 0);
    end

    // Saturation on both variants, one held beat and no consumer
    doReset();
    applyStimulus(1, 'hEE, 'h1EE, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("sat%0d.a_cnt", k), a_cnt, (k < 15) ? k : 15);
      checkOutput($sformatf("sat%0d.b_cnt", k), b_cnt, (k < 15) ? k : 15);
    end
    checkOutput("sat.a_data", a_od, 'hEE);
    checkOutput("sat.b_data", b_od, 'hEE);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("sat.a_drained", a_ov, 0);
    checkOutput("sat.a_cnt_kept", a_cnt, 15);
    checkOutput("sat.b_cnt_kept", b_cnt, 15);

    // SKID=0: backpressure keeps order, flush discards the beat taken that cycle
    doReset();
    applyStimulus(1, 'hA, 'h0AA, 0, 0, 0);
    checkOutput("ns0.ready", b_ir, 1);
    checkOutput("ns0.valid", b_ov, 0);
    applyStimulus(1, 'hB, 'h0BB, 0, 0, 0);
    checkOutput("ns1.ready", b_ir, 0);
    checkOutput("ns1.data", b_od, 'hA);
    applyStimulus(1, 'hB, 'h0BB, 0, 0, 0);
    checkOutput("ns2.ready", b_ir, 0);
    checkOutput("ns2.cnt", b_cnt, 1);
    applyStimulus(1, 'hB, 'h0BB, 0, 0, 1);
    checkOutput("ns3.ready", b_ir, 1);
    checkOutput("ns3.data", b_od, 'hA);
    checkOutput("ns3.cnt", b_cnt, 2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ns4.valid", b_ov, 1);
    checkOutput("ns4.data", b_od, 'hB);
    checkOutput("ns4.ctrl", b_oc, 'h0BB);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ns5.valid", b_ov, 0);
    checkOutput("ns5.ctrl", b_oc, 0);
    applyStimulus(1, 'h5A, 'h15A, 0, 0, 1);
    applyStimulus(1, 'h5B, 'h15B, 0, 1, 1);
    checkOutput("ns7.ready", b_ir, 1);
    checkOutput("ns7.data", b_od, 'h5A);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ns8.valid", b_ov, 0);
    checkOutput("ns8.ctrl", b_oc, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ns9.valid", b_ov, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
